// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer feeding the ALU operand ports.
// Routes each accepted word into buffered channel A or B.
module demux1to2_stream_chan #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign data_o  = mem_q[rd_q];
  assign pop     = valid_o & ready_i;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop)
      rd_d = rd_q + PW'(1);
    if (push_i)
      wr_d = wr_q + PW'(1);
    unique case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i)
        mem_q[wr_q] <= data_i;
    end
  end
endmodule

module demux1to2_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             auto_mode,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic             expect_b
);
  typedef enum logic {
    EXPECT_A = 1'b0,
    EXPECT_B = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   target;
  logic   full_a, full_b;
  logic   accept;
  logic   push_a, push_b;

  assign target   = auto_mode ? (state_q == EXPECT_B) : in_sel;
  assign in_ready = target ? ~full_b : ~full_a;
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & ~target;
  assign push_b   = accept & target;
  assign expect_b = (state_q == EXPECT_B);

  always_comb begin
    state_d = state_q;
    if (!auto_mode)
      state_d = EXPECT_A;
    else if (accept)
      state_d = (state_q == EXPECT_A) ? EXPECT_B : EXPECT_A;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= EXPECT_A;
    else
      state_q <= state_d;
  end

  demux1to2_stream_chan #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_chan_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_a),
    .data_i  (in_data),
    .ready_i (out_a_ready),
    .valid_o (out_a_valid),
    .data_o  (out_a_data),
    .full_o  (full_a)
  );

  demux1to2_stream_chan #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_chan_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_b),
    .data_i  (in_data),
    .ready_i (out_b_ready),
    .valid_o (out_b_valid),
    .data_o  (out_b_data),
    .full_o  (full_b)
  );
endmodule
